ysyx_23060072_ifu_fetch: RTL and testbench

Multi-cycle instruction fetch unit that sits directly upstream of the IF stage and replaces its zero-latency instruction memory lookup. It accepts one PC request at a time and issues a single-beat read on an AXI4-Lite-style read channel. It returns the instruction word, or a NOP plus an error flag, through a valid/ready response port. A flush from the controller cancels the request in flight; any bus data returned afterwards is discarded.

---
 rtl/ysyx_23060072_ifu_fetch.sv | 142 ++++++++++++++
 tb/tb_ysyx_23060072_ifu_fetch.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060072_ifu_fetch.sv
// Multi-cycle instruction fetch unit: one PC request at a time, a single-beat
// read on an AXI4-Lite-style channel, and the result on a valid/ready port.
module ysyx_23060072_ifu_fetch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    input  logic [31:0] req_addr_i,
    output logic        req_ready_o,
    input  logic        flush_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_pc_o,
    output logic [31:0] rsp_instr_o,
    output logic        rsp_err_o,
    output logic [31:0] araddr_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rvalid_i,
    output logic        rready_o
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10,
        RESP = 2'b11
    } state_t;

    state_t      state_r, state_s;
    logic        drop_r, drop_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] instr_r, instr_s;
    logic        err_r, err_s;
    logic        accept_s;
    logic        misalign_s;

    assign req_ready_o = !flush_i && ((state_r == IDLE) || ((state_r == RESP) && rsp_ready_i));
    assign accept_s    = req_valid_i && req_ready_o;
    assign misalign_s  = (req_addr_i[1:0] != 2'b00);

    assign arvalid_o   = (state_r == ADDR);
    assign rready_o    = (state_r == DATA);
    assign rsp_valid_o = (state_r == RESP);
    assign araddr_o    = pc_r;
    assign rsp_pc_o    = pc_r;
    assign rsp_instr_o = instr_r;
    assign rsp_err_o   = err_r;

    // Next-state and next-datapath decode.
    always_comb begin
        state_s = state_r;
        drop_s  = drop_r;
        pc_s    = pc_r;
        instr_s = instr_r;
        err_s   = err_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = misalign_s ? RESP : ADDR;
                end else begin
                    state_s = IDLE;
                end
            end
            ADDR: begin
                // The address beat is never withdrawn; a flush only marks the data for discard.
                if (arready_i) begin
                    state_s = DATA;
                end else begin
                    state_s = ADDR;
                end
                if (flush_i) begin
                    drop_s = 1'b1;
                end else begin
                    drop_s = drop_r;
                end
            end
            DATA: begin
                if (rvalid_i) begin
                    if (drop_r || flush_i) begin
                        drop_s  = 1'b0;
                        state_s = IDLE;
                    end else begin
                        instr_s = (rresp_i == 2'b00) ? rdata_i : NOP_INSTR;
                        err_s   = (rresp_i != 2'b00);
                        state_s = RESP;
                    end
                end else begin
                    if (flush_i) begin
                        drop_s = 1'b1;
                    end else begin
                        drop_s = drop_r;
                    end
                    state_s = DATA;
                end
            end
            RESP: begin
                if (flush_i) begin
                    state_s = IDLE;
                end else if (accept_s) begin
                    state_s = misalign_s ? RESP : ADDR;
                end else if (rsp_ready_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
                drop_s  = 1'b0;
            end
        endcase
        if (accept_s) begin
            pc_s    = req_addr_i;
            instr_s = NOP_INSTR;
            err_s   = misalign_s;
        end else begin
            pc_s = pc_r;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            drop_r  <= 1'b0;
            pc_r    <= 32'h0000_0000;
            instr_r <= NOP_INSTR;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            drop_r  <= drop_s;
            pc_r    <= pc_s;
            instr_r <= instr_s;
            err_r   <= err_s;
        end
    end

endmodule

// File: tb/tb_ysyx_23060072_ifu_fetch.sv
// Bench for ysyx_23060072_ifu_fetch: bus slave model, response scoreboard,
// a table of fetch vectors and hand-written flush/stall/reset sequences.
module tb_ysyx_23060072_ifu_fetch;

    logic        clk;
    logic        rst_n;
    logic        req_valid_i;
    logic [31:0] req_addr_i;
    logic        req_ready_o;
    logic        flush_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_pc_o;
    logic [31:0] rsp_instr_o;
    logic        rsp_err_o;
    logic [31:0] araddr_o;
    logic        arvalid_o;
    logic        arready_i;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        rvalid_i;
    logic        rready_o;

    ysyx_23060072_ifu_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_addr_i  (req_addr_i),
        .req_ready_o (req_ready_o),
        .flush_i     (flush_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_pc_o    (rsp_pc_o),
        .rsp_instr_o (rsp_instr_o),
        .rsp_err_o   (rsp_err_o),
        .araddr_o    (araddr_o),
        .arvalid_o   (arvalid_o),
        .arready_i   (arready_i),
        .rdata_i     (rdata_i),
        .rresp_i     (rresp_i),
        .rvalid_i    (rvalid_i),
        .rready_o    (rready_o)
    );

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        int          ar_wait;
        int          r_wait;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   n_rsp = 0;

    int          ar_wait_cfg = 0;
    int          r_wait_cfg = 0;
    logic [31:0] rdata_cfg = 32'h0;
    logic [1:0]  rresp_cfg = 2'b00;
    logic        r_pend = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Bus slave: counts wait cycles on AR and R, one outstanding beat.
    initial begin
        int   ar_cnt;
        int   r_cnt;
        logic ar_hs;
        logic r_hs;
        ar_cnt = 0; r_cnt = 0; ar_hs = 1'b0; r_hs = 1'b0;
        arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = 32'h0; rresp_i = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ar_cnt = 0; r_cnt = 0; ar_hs = 1'b0; r_hs = 1'b0; r_pend = 1'b0;
                arready_i = 1'b0; rvalid_i = 1'b0;
            end else begin
                if (r_hs) begin r_pend = 1'b0; r_hs = 1'b0; end
                if (ar_hs) begin r_pend = 1'b1; r_cnt = 0; ar_hs = 1'b0; end
                arready_i = 1'b0;
                if (arvalid_o) begin
                    if (ar_cnt >= ar_wait_cfg) begin
                        arready_i = 1'b1; ar_hs = 1'b1; ar_cnt = 0;
                    end else begin
                        ar_cnt++;
                    end
                end
                rvalid_i = 1'b0;
                if (r_pend && rready_o) begin
                    if (r_cnt >= r_wait_cfg) begin
                        rvalid_i = 1'b1; rdata_i = rdata_cfg; rresp_i = rresp_cfg;
                        r_hs = 1'b1; r_cnt = 0;
                    end else begin
                        r_cnt++;
                    end
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on every response handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && rsp_valid_o && rsp_ready_i) begin
                if (sb.size() == 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL unexpected_rsp: got pc %h with empty scoreboard", rsp_pc_o);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_pc", rsp_pc_o, e.pc);
                    chk("rsp_instr", rsp_instr_o, e.instr);
                    chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
                end
                n_rsp++;
            end
        end
    end

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr, input logic err);
        exp_t e;
        e.pc = pc; e.instr = instr; e.err = err;
        sb.push_back(e);
    endtask

    // Returns at the falling edge one cycle after the accept edge.
    task automatic issue(input logic [31:0] a);
        int t;
        t = 0;
        @(negedge clk);
        req_valid_i = 1'b1; req_addr_i = a;
        #1;
        while (!req_ready_o && t < 50) begin
            @(negedge clk); #1; t++;
        end
        if (!req_ready_o) begin
            n_vec++; n_miss++;
            $display("FAIL req_accept_timeout: got req_ready 0 required 1 for %h", a);
        end
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int t;
        t = 0;
        while (n_rsp < target && t < 60) begin
            @(negedge clk); t++;
        end
        if (n_rsp < target) begin
            n_vec++; n_miss++;
            $display("FAIL rsp_timeout: got %0d responses required %0d", n_rsp, target);
        end
    endtask

    task automatic set_bus(input int aw, input int rw, input logic [31:0] d, input logic [1:0] r);
        ar_wait_cfg = aw; r_wait_cfg = rw; rdata_cfg = d; rresp_cfg = r;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_arvalid"}, 32'(arvalid_o), 32'd0);
        chk({tag, "_rready"}, 32'(rready_o), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err_o), 32'd0);
        chk({tag, "_araddr"}, araddr_o, 32'h0);
        chk({tag, "_rsp_pc"}, rsp_pc_o, 32'h0);
        chk({tag, "_rsp_instr"}, rsp_instr_o, NOP);
    endtask

    initial begin
        vec_t tbl [7];
        int   n0;
        int   t;
        tbl[0] = '{32'h8000_0000, 0, 0, 32'h0050_0093, 2'b00, 32'h0050_0093, 1'b0};
        tbl[1] = '{32'h8000_0004, 2, 0, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 1'b0};
        tbl[2] = '{32'h8000_0008, 0, 3, 32'h1234_5673, 2'b00, 32'h1234_5673, 1'b0};
        tbl[3] = '{32'h8000_000C, 1, 1, 32'hAAAA_5555, 2'b10, NOP,           1'b1};
        tbl[4] = '{32'h8000_0040, 0, 0, 32'h0000_00FF, 2'b01, NOP,           1'b1};
        tbl[5] = '{32'h8000_0001, 0, 0, 32'h1111_1111, 2'b00, NOP,           1'b1};
        tbl[6] = '{32'h0000_0FFF, 0, 0, 32'h2222_2222, 2'b00, NOP,           1'b1};

        rst_n = 1'b0; req_valid_i = 1'b0; req_addr_i = 32'h0;
        flush_i = 1'b0; rsp_ready_i = 1'b1;
        @(negedge clk); @(negedge clk);
        chk_reset_vals("reset");
        chk("reset_req_ready", 32'(req_ready_o), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Minimum latency: valid exactly three cycles after the accept edge.
        set_bus(0, 0, 32'h0050_0093, 2'b00);
        push_exp(32'h8000_0000, 32'h0050_0093, 1'b0);
        n0 = n_rsp;
        issue(32'h8000_0000);
        chk("lat1_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("lat1_arvalid", 32'(arvalid_o), 32'd1);
        chk("lat1_araddr", araddr_o, 32'h8000_0000);
        @(negedge clk);
        chk("lat2_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("lat2_rready", 32'(rready_o), 32'd1);
        @(negedge clk);
        chk("lat3_rsp_valid", 32'(rsp_valid_o), 32'd1);
        wait_rsp(n0 + 1);

        // Misaligned request: response one cycle after acceptance, no bus beat.
        push_exp(32'h8000_0002, NOP, 1'b1);
        n0 = n_rsp;
        issue(32'h8000_0002);
        chk("mis_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("mis_arvalid", 32'(arvalid_o), 32'd0);
        wait_rsp(n0 + 1);

        for (int i = 0; i < 7; i++) begin
            set_bus(tbl[i].ar_wait, tbl[i].r_wait, tbl[i].rdata, tbl[i].rresp);
            push_exp(tbl[i].addr, tbl[i].instr, tbl[i].err);
            n0 = n_rsp;
            issue(tbl[i].addr);
            wait_rsp(n0 + 1);
        end

        // Flush while the address beat is stalled three cycles.
        set_bus(3, 0, 32'h3333_3333, 2'b00);
        n0 = n_rsp;
        issue(32'h8000_0100);
        flush_i = 1'b1;
        #1;
        chk("fa_req_ready", 32'(req_ready_o), 32'd0);
        chk("fa_arvalid1", 32'(arvalid_o), 32'd1);
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            if (c == 2) flush_i = 1'b0;
            chk($sformatf("fa_arvalid%0d", c), 32'(arvalid_o), (c <= 4) ? 32'd1 : 32'd0);
            chk($sformatf("fa_rsp_valid%0d", c), 32'(rsp_valid_o), 32'd0);
            if (c == 5) chk("fa_rready", 32'(rready_o), 32'd1);
            if (c == 6) begin
                #1;
                chk("fa_idle_req_ready", 32'(req_ready_o), 32'd1);
                chk("fa_r_consumed", 32'(r_pend), 32'd0);
            end
        end
        chk("fa_no_rsp", 32'(n_rsp), 32'(n0));

        // Response held four cycles, then handshake overlapped with a new request.
        set_bus(0, 0, 32'h1234_5678, 2'b00);
        rsp_ready_i = 1'b0;
        push_exp(32'h8000_0010, 32'h1234_5678, 1'b0);
        n0 = n_rsp;
        issue(32'h8000_0010);
        t = 0;
        while (!rsp_valid_o && t < 20) begin @(negedge clk); t++; end
        for (int k = 0; k < 4; k++) begin
            chk("hold_valid", 32'(rsp_valid_o), 32'd1);
            chk("hold_pc", rsp_pc_o, 32'h8000_0010);
            chk("hold_instr", rsp_instr_o, 32'h1234_5678);
            chk("hold_err", 32'(rsp_err_o), 32'd0);
            @(negedge clk);
        end
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b1; req_addr_i = 32'h8000_0020;
        rdata_cfg = 32'h00A0_0513;
        push_exp(32'h8000_0020, 32'h00A0_0513, 1'b0);
        #1;
        chk("b2b_req_ready", 32'(req_ready_o), 32'd1);
        @(negedge clk);
        req_valid_i = 1'b0;
        chk("b2b_arvalid", 32'(arvalid_o), 32'd1);
        chk("b2b_araddr", araddr_o, 32'h8000_0020);
        chk("b2b_rsp_valid", 32'(rsp_valid_o), 32'd0);
        wait_rsp(n0 + 2);

        // Flush in RESP: response withdrawn, request blocked that cycle.
        rsp_ready_i = 1'b0;
        n0 = n_rsp;
        issue(32'h8000_0206);
        chk("fr_rsp_valid", 32'(rsp_valid_o), 32'd1);
        flush_i = 1'b1; req_valid_i = 1'b1; req_addr_i = 32'h8000_0300;
        #1;
        chk("fr_req_ready", 32'(req_ready_o), 32'd0);
        @(negedge clk);
        flush_i = 1'b0; req_valid_i = 1'b0; rsp_ready_i = 1'b1;
        chk("fr_rsp_dropped", 32'(rsp_valid_o), 32'd0);
        chk("fr_arvalid", 32'(arvalid_o), 32'd0);
        #1;
        chk("fr_idle_req_ready", 32'(req_ready_o), 32'd1);
        chk("fr_no_rsp", 32'(n_rsp), 32'(n0));

        // Reset asserted in DATA, then a normal fetch.
        set_bus(0, 5, 32'h4444_4444, 2'b00);
        issue(32'h8000_0400);
        @(negedge clk);
        chk("rd_rready", 32'(rready_o), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_data");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        set_bus(0, 0, 32'h0010_0073, 2'b00);
        push_exp(32'h8000_0500, 32'h0010_0073, 1'b0);
        n0 = n_rsp;
        issue(32'h8000_0500);
        wait_rsp(n0 + 1);

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
